// File: rtl/gcd_pkg.sv
// +------------------------------------------------------------------+
// | gcd_pkg: shared state encoding and default widths for gcd_core   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int GCD_WIDTH  = 8;
  localparam int GCD_ITER_W = 16;

endpackage

`default_nettype wire

// File: rtl/gcd_step.sv
// +------------------------------------------------------------------+
// | gcd_step: one combinational subtract/swap Euclid step            |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gcd_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o,
  output logic             done_o,
  output logic             step_o
);

  always_comb begin
    a_o    = a_i;
    b_o    = b_i;
    done_o = 1'b0;
    step_o = 1'b0;
    if (b_i == '0) begin
      done_o = 1'b1;
    end else if (a_i < b_i) begin
      a_o    = b_i;
      b_o    = a_i;
      step_o = 1'b1;
    end else begin
      // a_i >= b_i here, so the subtraction cannot underflow
      a_o    = a_i - b_i;
      step_o = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gcd_core.sv
// +------------------------------------------------------------------+
// | gcd_core: iterative Euclid GCD engine with valid/ready handshakes|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module gcd_core
  import gcd_pkg::*;
#(
  parameter int WIDTH  = GCD_WIDTH,
  parameter int ITER_W = GCD_ITER_W
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  a_in,
  input  logic [WIDTH-1:0]  b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  result,
  output logic [ITER_W-1:0] iter_count,
  output logic              busy
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [ITER_W-1:0]  iter_q, iter_d;

  logic [WIDTH-1:0]   w_step_a;
  logic [WIDTH-1:0]   w_step_b;
  logic               w_step_done;
  logic               w_step_take;

  gcd_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i    (a_q),
    .b_i    (b_q),
    .a_o    (w_step_a),
    .b_o    (w_step_b),
    .done_o (w_step_done),
    .step_o (w_step_take)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    iter_d   = iter_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_in;
          b_d     = b_in;
          iter_d  = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (w_step_done) begin
          result_d = a_q;
          state_d  = DONE;
        end else begin
          a_d = w_step_a;
          b_d = w_step_b;
          // Counter sticks at all-ones instead of wrapping
          if (w_step_take && !(&iter_q)) begin
            iter_d = iter_q + ITER_W'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      iter_q   <= iter_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q == CALC);
  assign result     = result_q;
  assign iter_count = iter_q;

endmodule

`default_nettype wire

// File: tb/tb_gcd_core.sv
// +------------------------------------------------------------------+
// | tb_gcd_core: directed self-checking bench for gcd_core           |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_gcd_core;

  logic        CLOCK_50;
  logic        reset;
  logic        in_valid;
  logic [7:0]  a_in;
  logic [7:0]  b_in;
  logic        out_ready;

  logic        in_ready,  in_ready_s;
  logic        out_valid, out_valid_s;
  logic        busy,      busy_s;
  logic [7:0]  result,    result_s;
  logic [15:0] iter_count;
  logic [3:0]  iter_count_s;

  int total_cnt = 0;
  int bad_cnt   = 0;

  gcd_core #(
    .WIDTH  (8),
    .ITER_W (16)
  ) u_dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .iter_count (iter_count),
    .busy       (busy)
  );

  // Narrow counter copy, shares all inputs with the main instance
  gcd_core #(
    .WIDTH  (8),
    .ITER_W (4)
  ) u_dut_sat (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready_s),
    .a_in       (a_in),
    .b_in       (b_in),
    .out_valid  (out_valid_s),
    .out_ready  (out_ready),
    .result     (result_s),
    .iter_count (iter_count_s),
    .busy       (busy_s)
  );

  initial begin
    CLOCK_50 = 1'b0;
    forever #5 CLOCK_50 = ~CLOCK_50;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run_pair(input logic [7:0] a, input logic [7:0] b,
                          input int exp_res, input int exp_iter,
                          input int exp_cyc, input bit hold);
    int cnt;
    int exp_sat;
    exp_sat = (exp_iter > 15) ? 15 : exp_iter;
    @(negedge CLOCK_50);
    check_val("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    a_in     = ~a;
    b_in     = ~b;
    check_val("busy_calc", 32'(busy), 1);
    check_val("in_ready_calc", 32'(in_ready), 0);
    cnt = 0;
    while (!out_valid && cnt < 2000) begin
      in_valid = (cnt == 0);
      out_ready = (cnt == 0);
      @(negedge CLOCK_50);
      cnt++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_val("calc_edges", 32'(cnt), 32'(exp_cyc));
    check_val("result", 32'(result), 32'(exp_res));
    check_val("iter_count", 32'(iter_count), 32'(exp_iter));
    check_val("result_sat", 32'(result_s), 32'(exp_res));
    check_val("iter_count_sat", 32'(iter_count_s), 32'(exp_sat));
    if (hold) begin
      for (int i = 0; i < 10; i++) begin
        in_valid = (i == 3);
        a_in     = 8'd1;
        b_in     = 8'd1;
        @(negedge CLOCK_50);
        check_val("hold_valid", 32'(out_valid), 1);
        check_val("hold_result", 32'(result), 32'(exp_res));
        check_val("hold_in_ready", 32'(in_ready), 0);
      end
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    out_ready = 1'b0;
    check_val("out_valid_drop", 32'(out_valid), 0);
    check_val("in_ready_back", 32'(in_ready), 1);
    check_val("result_kept", 32'(result), 32'(exp_res));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    reset = 1'b0;
    check_val("rst_in_ready", 32'(in_ready), 1);
    check_val("rst_out_valid", 32'(out_valid), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_result", 32'(result), 0);
    check_val("rst_iter", 32'(iter_count), 0);

    // out_ready in IDLE is ignored
    out_ready = 1'b1;
    @(negedge CLOCK_50);
    out_ready = 1'b0;
    check_val("idle_out_ready", 32'(in_ready), 1);

    run_pair(8'd12,  8'd8,  4, 5,   6,   1'b0);
    run_pair(8'd0,   8'd0,  0, 0,   1,   1'b0);
    run_pair(8'd0,   8'd7,  7, 1,   2,   1'b0);
    run_pair(8'd7,   8'd0,  7, 0,   1,   1'b0);
    run_pair(8'd255, 8'd1,  1, 256, 257, 1'b0);
    run_pair(8'd21,  8'd14, 7, 5,   6,   1'b1);

    // Abort (200,3) mid-calculation
    @(negedge CLOCK_50);
    in_valid = 1'b1;
    a_in     = 8'd200;
    b_in     = 8'd3;
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    check_val("mid_busy", 32'(busy), 1);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    check_val("abort_in_ready", 32'(in_ready), 1);
    check_val("abort_out_valid", 32'(out_valid), 0);
    check_val("abort_busy", 32'(busy), 0);
    check_val("abort_iter", 32'(iter_count), 0);
    check_val("abort_result", 32'(result), 0);

    run_pair(8'd9, 8'd6, 3, 5, 6, 1'b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gcd_core.md
Name: gcd_core

Overview:
- Iterative Euclid GCD engine (subtract/swap form) with valid/ready handshakes on both operand input and result output.
- Sits inside the GCD wrapper. It is clocked by the divided DUT clock, and its result feeds the LEDR display path.
- Accepts one operand pair, iterates one step per clock, then holds the result until the consumer takes it.
- Also reports the step count, for debug and LED display.

Parameters:
- WIDTH, 8, operand and result width in bits.
- ITER_W, 16, width of the step counter. The counter saturates at its maximum value.

Ports:
- CLOCK_50  in  1  block clock. The parent drives it with the divided DUT clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a_in/b_in is valid.
- in_ready  out  1  block can accept an operand pair. High only in IDLE.
- a_in  in  WIDTH  operand A, unsigned.
- b_in  in  WIDTH  operand B, unsigned.
- out_valid  out  1  result is valid. High only in DONE.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  gcd(A,B). Held stable while out_valid is high.
- iter_count  out  ITER_W  number of subtract/swap steps taken for the current or last result.
- busy  out  1  high in CALC.

Behaviour:
- All state changes on the rising edge of CLOCK_50. Reset is synchronous, active-high, and applies only on a clock edge.
- Reset values:
  - state = IDLE
  - A = 0, B = 0
  - result = 0
  - iter_count = 0
  - out_valid = 0, busy = 0
  - in_ready = 1 (combinational from state)
- States: IDLE, CALC, DONE. Encoding is binary, 2 bits.
- IDLE:
  - in_ready = 1.
  - When in_valid = 1 at an edge, load A <= a_in, B <= b_in, clear iter_count, and go to CALC.
  - When in_valid = 0, stay in IDLE.
- CALC: exactly one action per edge, checked in this priority order:
  1. B == 0: result <= A, go to DONE. iter_count is unchanged.
  2. A < B: swap A and B; iter_count += 1 (saturating).
  3. Otherwise: A <= A - B; iter_count += 1 (saturating).
- Arithmetic:
  - Unsigned; the subtraction is WIDTH bits wide and cannot underflow because A >= B is guaranteed at that point.
  - No widening.
- DONE:
  - out_valid = 1. result and iter_count are held.
  - When out_ready = 1 at an edge, go to IDLE; out_valid falls after that edge.
  - A new pair is not accepted on the same edge as the result handoff; in_ready rises only in IDLE.
- Latency: 1 edge to accept, then (steps + 1) CALC edges, then out_valid is high. There is no fixed upper bound; the worst case is about 2^WIDTH steps.
- Boundary cases:
  - gcd(0,0) = 0.
  - gcd(0,x) = gcd(x,0) = x.
  - in_valid is ignored in CALC and DONE; in_ready = 0 there.
  - a_in/b_in changing during CALC has no effect.
  - out_ready = 1 while in IDLE or CALC is ignored.
  - Reset in any state returns to IDLE on the same edge and discards any in-flight operation and result.
  - iter_count saturates at 2^ITER_W - 1 and never wraps.
  - result keeps the last computed value in IDLE (registered, not cleared).
- Output registers: no combinational path from in_valid to out_valid. in_ready, out_valid and busy are decoded from the state register only.

Decomposition:
- Shared package gcd_pkg:
  - state enum: IDLE, CALC, DONE
  - default WIDTH constant (8)
  - default ITER_W constant (16)
- Sub-module: one is natural, gcd_step. It is combinational and takes A and B. It returns next A, next B, a "done" flag (B == 0) and a "step" flag (swap or subtract).
- gcd_core then holds the FSM, the registers and the saturating counter.

Test Plan:
- a=12, b=8 -> accepted at edge 0. Steps: A 12→4, swap (A=8, B=4), A 8→4, A 4→0, swap (A=4, B=0), done. out_valid high after edge 6 with result = 4 and iter_count = 5.
- a=0, b=0 -> out_valid after 1 CALC edge with result = 0 and iter_count = 0. Then a=0, b=7 -> result = 7 and iter_count = 1.
- a=255, b=1 -> result = 1 and iter_count = 256 (255 subtracts plus 1 swap). out_valid rises 257 CALC edges after acceptance.
- Backpressure: (21,14) completes with out_ready = 0 held for 10 cycles -> out_valid stays 1, and result = 7 stays stable throughout. in_valid pulsed during this window is ignored (in_ready = 0). Raising out_ready -> IDLE on the next edge.
- Reset mid-CALC during (200,3) -> on the next edge state = IDLE, out_valid = 0, iter_count = 0, in_ready = 1. A following pair (9,6) yields result = 3.
- Saturation with ITER_W = 4: a=255, b=1 -> iter_count holds at 15 with no wrap, and result = 1.
